// File: rtl/fp_mult_pkg.sv
// Shared operand classes, flag bundle and format constants for the pipelined FP multiplier.
package fp_mult_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN in the low 1+exp_w+man_w bits (formats up to 64 bits wide).
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    // Subnormals (exp == 0) are deliberately classed as zero.
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic man_zero);
        if (exp_zero) return ZERO;
        if (exp_ones) return man_zero ? INF : NAN;
        return NORM;
    endfunction

endpackage

// File: rtl/fp_mult_norm_round.sv
// Stage-2 combinational logic: normalise the raw mantissa product, round to nearest even,
// and resolve special operands plus exponent overflow/underflow into the final result.
module fp_mult_norm_round
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    sign,
    input  fp_class_e               cls_a,
    input  fp_class_e               cls_b,
    input  logic signed [EXP_W+1:0] exp_sum,
    input  logic [2*MAN_W+1:0]      prod,
    output logic [EXP_W+MAN_W:0]    result,
    output fp_flags_t               flags
);

    localparam logic [63:0]             QNAN_ALL = fp_qnan(EXP_W, MAN_W);
    localparam logic [EXP_W+MAN_W:0]    QNAN     = QNAN_ALL[EXP_W+MAN_W:0];
    localparam logic signed [EXP_W+1:0] EXP_ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};

    logic [MAN_W-1:0]        frac;
    logic [MAN_W:0]          frac_r;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic signed [EXP_W+1:0] exp_norm;
    logic signed [EXP_W+1:0] exp_fin;
    logic                    nan_c;
    logic                    inf_c;
    logic                    zero_c;

    always_comb begin
        if (prod[2*MAN_W+1]) begin
            frac     = prod[2*MAN_W:MAN_W+1];
            guard    = prod[MAN_W];
            sticky   = |prod[MAN_W-1:0];
            exp_norm = exp_sum + EXP_ONE;
        end else begin
            frac     = prod[2*MAN_W-1:MAN_W];
            guard    = prod[MAN_W-1];
            sticky   = |prod[MAN_W-2:0];
            exp_norm = exp_sum;
        end
        round_up = guard & (sticky | frac[0]);
        // A carry out of the fraction leaves it all-zero, i.e. mantissa 1.0 at exponent+1.
        frac_r  = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        exp_fin = frac_r[MAN_W] ? exp_norm + EXP_ONE : exp_norm;
    end

    always_comb begin
        nan_c  = (cls_a == NAN) || (cls_b == NAN) ||
                 ((cls_a == INF) && (cls_b == ZERO)) ||
                 ((cls_a == ZERO) && (cls_b == INF));
        inf_c  = (cls_a == INF) || (cls_b == INF);
        zero_c = (cls_a == ZERO) || (cls_b == ZERO);
        flags  = '0;
        result = {sign, exp_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
        if (nan_c) begin
            result          = QNAN;
            flags.exception = 1'b1;
        end else if (inf_c) begin
            result          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags.exception = 1'b1;
            flags.overflow  = 1'b1;
        end else if (zero_c) begin
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (exp_fin >= EXP_MAX) begin
            result         = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags.overflow = 1'b1;
        end else if (exp_fin[EXP_W+1] || (exp_fin == '0)) begin
            result          = {sign, {(EXP_W+MAN_W){1'b0}}};
            flags.underflow = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-754 multiplier: product stage, normalise/round stage, then pure delay stages,
// all under valid/ready flow control where empty stages absorb data even while the output stalls.
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_operand,
    input  logic [EXP_W+MAN_W:0]   b_operand,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   Exception,
    output logic                   Overflow,
    output logic                   Underflow
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int BIAS = fp_bias(EXP_W);
    localparam logic signed [EXP_W+1:0] BIAS_S = BIAS[EXP_W+1:0];

    typedef struct packed {
        logic                    sign;
        fp_class_e               cls_a;
        fp_class_e               cls_b;
        logic signed [EXP_W+1:0] exp_sum;
        logic [PW-1:0]           prod;
        logic [TAG_W-1:0]        tag;
    } prod_stage_t;

    typedef struct packed {
        logic [W-1:0]     result;
        fp_flags_t        flags;
        logic [TAG_W-1:0] tag;
    } result_stage_t;

    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;

    prod_stage_t   s1_d;
    prod_stage_t   s1_q;
    result_stage_t s2_d;
    result_stage_t sn_q [2:STAGES];

    logic [STAGES:1] vld;
    logic [STAGES:1] ld;

    assign a_exp = a_operand[W-2:MAN_W];
    assign b_exp = b_operand[W-2:MAN_W];
    assign a_man = a_operand[MAN_W-1:0];
    assign b_man = b_operand[MAN_W-1:0];

    always_comb begin
        s1_d.sign    = a_operand[W-1] ^ b_operand[W-1];
        s1_d.cls_a   = fp_classify(a_exp == '0, &a_exp, a_man == '0);
        s1_d.cls_b   = fp_classify(b_exp == '0, &b_exp, b_man == '0);
        s1_d.exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;
        s1_d.prod    = {{(MAN_W+1){1'b0}}, 1'b1, a_man} * {{(MAN_W+1){1'b0}}, 1'b1, b_man};
        s1_d.tag     = in_tag;
    end

    fp_mult_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .sign    (s1_q.sign),
        .cls_a   (s1_q.cls_a),
        .cls_b   (s1_q.cls_b),
        .exp_sum (s1_q.exp_sum),
        .prod    (s1_q.prod),
        .result  (s2_d.result),
        .flags   (s2_d.flags)
    );
    assign s2_d.tag = s1_q.tag;

    // Load chain from the output backwards: a stage loads when empty or when its successor moves.
    always_comb begin
        logic nxt;
        ld  = '0;
        nxt = !vld[STAGES] || out_ready;
        ld[STAGES] = nxt;
        for (int k = STAGES - 1; k >= 1; k--) begin
            nxt   = !vld[k] || nxt;
            ld[k] = nxt;
        end
    end

    assign in_ready = ld[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= '0;
            s1_q <= '0;
            for (int k = 2; k <= STAGES; k++) sn_q[k] <= '0;
        end else begin
            if (ld[1]) begin
                vld[1] <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (ld[2]) begin
                vld[2] <= vld[1];
                if (vld[1]) sn_q[2] <= s2_d;
            end
            for (int k = 3; k <= STAGES; k++) begin
                if (ld[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) sn_q[k] <= sn_q[k-1];
                end
            end
        end
    end

    assign out_valid = vld[STAGES];
    assign result    = sn_q[STAGES].result;
    assign out_tag   = sn_q[STAGES].tag;
    assign Exception = sn_q[STAGES].flags.exception;
    assign Overflow  = sn_q[STAGES].flags.overflow;
    assign Underflow = sn_q[STAGES].flags.underflow;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: directed vectors with hand-computed single-precision products.
module tb_fp_mult_pipe;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int STAGES = 3;
    localparam int TAG_W  = 4;
    localparam int W      = 1 + EXP_W + MAN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a_operand;
    logic [W-1:0]     b_operand;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] out_tag;
    logic             Exception;
    logic             Overflow;
    logic             Underflow;

    always #5 clk = ~clk;

    fp_mult_pipe #(
        .EXP_W  (EXP_W),
        .MAN_W  (MAN_W),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    // flags field is {Exception, Overflow, Underflow}
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
        int          issue_cyc;
        bit          lat_chk;
    } exp_t;

    vec_t vecs [19] = '{
        '{32'h45800000, 32'h45800000, 32'h4B800000, 3'b000},
        '{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000},
        '{32'hBFC00000, 32'h40000000, 32'hC0400000, 3'b000},
        '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000},
        '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010},
        '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001},
        '{32'h7F800000, 32'h7F800000, 32'h7F800000, 3'b110},
        '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100},
        '{32'hC1526666, 32'h00000000, 32'h80000000, 3'b000},
        '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000},
        '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000},
        '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 3'b000},
        '{32'hFF800001, 32'h3F800000, 32'h7FC00000, 3'b100},
        '{32'h00400000, 32'h40000000, 32'h00000000, 3'b000},
        '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b110},
        '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000},
        '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010},
        '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000},
        '{32'h80800000, 32'h3F000000, 32'h80000000, 3'b001}
    };

    exp_t        q [$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          inflight = 0;
    logic        stall_prev = 1'b0;
    logic [38:0] out_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: in_ready model, hold-while-stalled, and in-order scoreboard on each output transfer.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            inflight   = 0;
        end else begin
            check("in_ready", {63'b0, in_ready}, {63'b0, !((inflight == STAGES) && !out_ready)});
            if (stall_prev) begin
                check("hold_valid", {63'b0, out_valid}, 64'd1);
                check("hold_data", {25'b0, result, out_tag, Exception, Overflow, Underflow},
                      {25'b0, out_prev});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: actual=%h tag=%h required=none", result, out_tag);
                end else begin
                    mon_e = q.pop_front();
                    check("result", {32'b0, result}, {32'b0, mon_e.res});
                    check("tag", {60'b0, out_tag}, {60'b0, mon_e.tag});
                    check("flags", {61'b0, Exception, Overflow, Underflow}, {61'b0, mon_e.flg});
                    if (mon_e.lat_chk)
                        check("latency", 64'(cyc - mon_e.issue_cyc), 64'(STAGES));
                end
            end
            inflight   = inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            stall_prev = out_valid && !out_ready;
            out_prev   = {result, out_tag, Exception, Overflow, Underflow};
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the operands were accepted.
    task automatic send(input int idx, input logic [3:0] tag, input bit lat);
        exp_t e;
        int   n;
        n         = 0;
        a_operand = vecs[idx].a;
        b_operand = vecs[idx].b;
        in_tag    = tag;
        in_valid  = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                e.res       = vecs[idx].r;
                e.tag       = tag;
                e.flg       = vecs[idx].f;
                e.issue_cyc = cyc;
                e.lat_chk   = lat;
                q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout: actual=in_ready_low required=accept vec=%0d", idx);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n        = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [15:0] rdy_pat;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a_operand = '0;
        b_operand = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        rdy_pat   = 16'b1011_0010_0111_0001;
        @(posedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_data", {25'b0, result, out_tag, Exception, Overflow, Underflow}, 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // back-to-back first pair with exact-latency checks, then the remaining directed vectors
        send(0, 4'h1, 1'b1);
        send(1, 4'h2, 1'b1);
        drain();
        for (int i = 2; i < 19; i++) send(i, 4'(i), 1'b1);
        drain();

        // streaming under a backpressure pattern
        fork
            begin
                for (int i = 0; i < 8; i++) send(4 + i, 4'(8 + i), 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 48; i++) begin
                    out_ready = rdy_pat[i % 16];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with two operations in flight, output stalled
        out_ready = 1'b0;
        send(2, 4'hA, 1'b0);
        send(3, 4'hB, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_valid", {63'b0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        q.delete();
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_data", {25'b0, result, out_tag, Exception, Overflow, Underflow}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(9, 4'hC, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
